// File: rtl/quiz2_pkg.sv
// Shared helpers for the slot-multiplexed FIFO block: slot preference and
// FIFO pointer width.
package quiz2_pkg;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // Lower half of the counter range prefers channel 0, upper half channel 1.
    function automatic logic slot_pref(input int unsigned count, input int unsigned max_val);
        return (count >= (max_val / 2)) ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/fifo_sync.sv
// Small synchronous FIFO with one extra pointer bit to tell full from empty.
// Push while full and pop while empty are ignored.
module fifo_sync
    import quiz2_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [DATA_W-1:0]        wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_width(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign level   = wr_ptr - rd_ptr;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage needs no reset: contents are only visible between the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/fifo_slot_mux.sv
// Two-channel FIFO merge onto one registered output; the counter slot picks the
// preferred channel, the other is served when it is empty. Option: FIFO_SLOT_MUX_STATUS_EN.
module fifo_slot_mux
    import quiz2_pkg::*;
#(
    parameter int MAX_VAL = 16,
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [$clog2(MAX_VAL)-1:0]  count,
    input  logic                        wr_vld0,
    input  logic [DATA_W-1:0]           wr_data0,
    output logic                        wr_rdy0,
    input  logic                        wr_vld1,
    input  logic [DATA_W-1:0]           wr_data1,
    output logic                        wr_rdy1,
    output logic                        out_vld,
    input  logic                        out_rdy,
    output logic [DATA_W-1:0]           out_data,
    output logic                        out_ch
`ifdef FIFO_SLOT_MUX_STATUS_EN
    ,
    output logic [$clog2(DEPTH):0]      lvl0,
    output logic [$clog2(DEPTH):0]      lvl1,
    output logic                        ovf
`endif
);

    logic [DATA_W-1:0] rd_data0, rd_data1;
    logic              full0, full1, empty0, empty1;
    logic              pop0, pop1;
    logic              pref;
    logic              load;

    fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo0 (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_vld0),
        .pop     (pop0),
        .wr_data (wr_data0),
        .rd_data (rd_data0),
        .full    (full0),
        .empty   (empty0),
`ifdef FIFO_SLOT_MUX_STATUS_EN
        .level   (lvl0)
`else
        .level   ()
`endif
    );

    fifo_sync #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_vld1),
        .pop     (pop1),
        .wr_data (wr_data1),
        .rd_data (rd_data1),
        .full    (full1),
        .empty   (empty1),
`ifdef FIFO_SLOT_MUX_STATUS_EN
        .level   (lvl1)
`else
        .level   ()
`endif
    );

    assign wr_rdy0 = !full0;
    assign wr_rdy1 = !full1;
    assign pref    = slot_pref(32'(count), MAX_VAL);
    assign load    = !out_vld || out_rdy;

    always_comb begin
        pop0 = 1'b0;
        pop1 = 1'b0;
        if (load) begin
            if (!pref) begin
                if (!empty0)      pop0 = 1'b1;
                else if (!empty1) pop1 = 1'b1;
            end else begin
                if (!empty1)      pop1 = 1'b1;
                else if (!empty0) pop0 = 1'b1;
            end
        end
    end

    // When nothing is available the word and channel are kept, only valid drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_data <= '0;
            out_ch   <= 1'b0;
        end else if (load) begin
            if (pop0) begin
                out_vld  <= 1'b1;
                out_data <= rd_data0;
                out_ch   <= 1'b0;
            end else if (pop1) begin
                out_vld  <= 1'b1;
                out_data <= rd_data1;
                out_ch   <= 1'b1;
            end else begin
                out_vld  <= 1'b0;
            end
        end
    end

`ifdef FIFO_SLOT_MUX_STATUS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if ((wr_vld0 && !wr_rdy0) || (wr_vld1 && !wr_rdy1)) begin
            ovf <= 1'b1;
        end
    end
`endif

endmodule
